// File: rtl/onehot_req_arbiter.sv
// Round-robin request arbiter feeding an 8x3 encoder: captures request lines
// into a pending register and offers one registered one-hot grant at a time.
module onehot_req_arbiter #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_req,
  output logic [7:0] o_gnt_onehot,
  output logic       o_gnt_valid,
  input  logic       i_gnt_ready,
  output logic [7:0] o_pending,
  output logic       o_overflow
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     r_state;
  logic [7:0] r_req_q;
  logic [7:0] r_pending;
  logic [7:0] r_gnt_onehot;
  logic       r_gnt_valid;
  logic       r_overflow;
  logic [2:0] r_rr_ptr;

  logic [7:0] w_new;
  logic       w_acc;
  logic [7:0] w_rem;
  logic [2:0] w_gnt_idx;
  logic [2:0] w_next_ptr;
  logic [7:0] w_pick;

  // First set bit at or after p, wrapping 7->0; scanned backwards so the
  // smallest offset from p is the one that sticks.
  function automatic logic [7:0] f_pick(input logic [7:0] v, input logic [2:0] p);
    logic [7:0] g;
    logic [2:0] j;
    g = '0;
    for (int k = 7; k >= 0; k--) begin
      j = p + 3'(k);
      if (v[j]) g = 8'b1 << j;
    end
    return g;
  endfunction

  always_comb begin
    w_new     = EDGE_MODE ? (i_req & ~r_req_q) : i_req;
    w_acc     = r_gnt_valid & i_gnt_ready;
    w_rem     = w_acc ? (r_pending & ~r_gnt_onehot) : r_pending;
    w_gnt_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_gnt_onehot[i]) w_gnt_idx = w_gnt_idx | 3'(i);
    end
    w_next_ptr = w_acc ? (w_gnt_idx + 3'd1) : r_rr_ptr;
    // In IDLE nothing is accepted, so this is simply a pick from pending.
    w_pick = f_pick(w_rem, w_next_ptr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req_q      <= '0;
      r_pending    <= '0;
      r_gnt_onehot <= '0;
      r_gnt_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_rr_ptr     <= '0;
    end else begin
      r_req_q    <= i_req;
      // A fresh edge on the bit being accepted re-pends it rather than being lost.
      r_pending  <= w_rem | w_new;
      r_overflow <= EDGE_MODE ? |(w_new & w_rem) : 1'b0;
      case (r_state)
        IDLE: begin
          if (|r_pending) begin
            r_gnt_onehot <= w_pick;
            r_gnt_valid  <= 1'b1;
            r_state      <= OFFER;
          end
        end
        OFFER: begin
          if (w_acc) begin
            r_rr_ptr <= w_next_ptr;
            if (|w_rem) begin
              r_gnt_onehot <= w_pick;
            end else begin
              r_gnt_onehot <= '0;
              r_gnt_valid  <= 1'b0;
              r_state      <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_gnt_onehot = r_gnt_onehot;
  assign o_gnt_valid  = r_gnt_valid;
  assign o_pending    = r_pending;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// Directed bench for onehot_req_arbiter: an index-level round-robin model is
// compared every cycle, and literal expectations pin the key scenarios.
module tb_onehot_req_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_req;
  logic       i_gnt_ready;
  logic [7:0] o_gnt_onehot;
  logic       o_gnt_valid;
  logic [7:0] o_pending;
  logic       o_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  onehot_req_arbiter #(.EDGE_MODE(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req        (i_req),
    .o_gnt_onehot (o_gnt_onehot),
    .o_gnt_valid  (o_gnt_valid),
    .i_gnt_ready  (i_gnt_ready),
    .o_pending    (o_pending),
    .o_overflow   (o_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending set, granted index (-1 = none), pointer as plain integers.
  typedef struct {
    logic [7:0] req_q;
    logic [7:0] pend;
    int         gnt;
    int         ptr;
    bit         ovf;
  } mstate_t;

  mstate_t m;
  int      acc_q[$];

  function automatic mstate_t step(input mstate_t s, input logic [7:0] req, input bit rdy);
    mstate_t    n;
    logic [7:0] newb;
    logic [7:0] rem;
    bit         acc;
    n    = s;
    newb = req & ~s.req_q;
    acc  = (s.gnt >= 0) && rdy;
    rem  = s.pend;
    if (acc) rem[s.gnt] = 1'b0;
    n.req_q = req;
    n.ovf   = |(newb & rem);
    n.pend  = rem | newb;
    if (acc) n.ptr = (s.gnt + 1) % 8;
    if (s.gnt < 0 || acc) begin
      n.gnt = -1;
      for (int k = 0; k < 8; k++) begin
        if (n.gnt < 0 && rem[(n.ptr + k) % 8]) n.gnt = (n.ptr + k) % 8;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_oh(input int g);
    logic [7:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic int enc(input logic [7:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{req_q: 8'h00, pend: 8'h00, gnt: -1, ptr: 0, ovf: 1'b0};
    end else begin
      if (m.gnt >= 0 && i_gnt_ready) acc_q.push_back(m.gnt);
      m <= step(m, i_req, i_gnt_ready);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_gnt",      o_gnt_onehot, exp_oh(m.gnt));
      chk("cmp_valid",    o_gnt_valid,  m.gnt >= 0);
      chk("cmp_pending",  o_pending,    m.pend);
      chk("cmp_overflow", o_overflow,   m.ovf);
      chk("inv_onehot",   $countones(o_gnt_onehot) <= 1, 1);
      if (o_gnt_valid) chk("inv_in_pending", |(o_gnt_onehot & o_pending), 1);
    end
  end

  task automatic chk_acc(input string name, input int exp[$]);
    chk({name, "_count"}, acc_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < acc_q.size(); i++)
      chk({name, "_idx"}, acc_q[i], exp[i]);
  endtask

  initial begin
    rst_n = 1'b1;
    i_req = 8'h00;
    i_gnt_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    i_req = 8'hFF;
    cmp_en = 1'b1;

    // Reset with all requests high; they count as edges after release.
    repeat (3) @(negedge clk);
    chk("rst_gnt", o_gnt_onehot, 8'h00);
    chk("rst_valid", o_gnt_valid, 1'b0);
    chk("rst_pending", o_pending, 8'h00);
    chk("rst_overflow", o_overflow, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_pending", o_pending, 8'hFF);
    chk("t1_valid_early", o_gnt_valid, 1'b0);
    @(negedge clk);
    chk("t1_first_gnt", o_gnt_onehot, 8'h01);
    chk("t1_valid", o_gnt_valid, 1'b1);
    @(negedge clk);
    chk("t1_hold", o_gnt_onehot, 8'h01);
    acc_q.delete();
    i_gnt_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("t3_burst_gnt", o_gnt_onehot, 32'(8'h01 << i));
      chk("t3_burst_valid", o_gnt_valid, 1'b1);
    end
    @(negedge clk);
    chk("t3_end_valid", o_gnt_valid, 1'b0);
    chk("t3_end_pending", o_pending, 8'h00);
    chk_acc("t3_order", '{0, 1, 2, 3, 4, 5, 6, 7});
    i_req = 8'h00;

    // Single pulse on req[5]: grant 2 cycles after the edge, code 3'b101.
    acc_q.delete();
    @(negedge clk) i_req = 8'h20;
    @(negedge clk) i_req = 8'h00;
    chk("t2_pending", o_pending, 8'h20);
    chk("t2_valid_early", o_gnt_valid, 1'b0);
    @(negedge clk);
    chk("t2_gnt", o_gnt_onehot, 8'h20);
    chk("t2_valid", o_gnt_valid, 1'b1);
    chk("t2_code", enc(o_gnt_onehot), 5);
    @(negedge clk);
    chk("t2_valid_drop", o_gnt_valid, 1'b0);
    chk("t2_pending_clear", o_pending, 8'h00);
    chk_acc("t2_order", '{5});

    // Stalled grant from pending 8'h24 with pointer at 6.
    acc_q.delete();
    i_gnt_ready = 1'b0;
    @(negedge clk) i_req = 8'h24;
    @(negedge clk) i_req = 8'h00;
    chk("t4_pending", o_pending, 8'h24);
    @(negedge clk);
    chk("t4_gnt", o_gnt_onehot, 8'h04);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_stall_gnt", o_gnt_onehot, 8'h04);
      chk("t4_stall_valid", o_gnt_valid, 1'b1);
    end
    i_gnt_ready = 1'b1;
    @(negedge clk);
    chk("t4_next_gnt", o_gnt_onehot, 8'h20);
    chk("t4_next_pending", o_pending, 8'h20);
    @(negedge clk);
    chk("t4_done", o_gnt_valid, 1'b0);
    chk_acc("t4_order", '{2, 5});
    i_gnt_ready = 1'b0;

    // Second edge on req[3] while its grant is stalled -> one overflow pulse.
    acc_q.delete();
    @(negedge clk) i_req = 8'h08;
    @(negedge clk) i_req = 8'h00;
    @(negedge clk);
    chk("t5_gnt", o_gnt_onehot, 8'h08);
    chk("t5_no_ovf", o_overflow, 1'b0);
    i_req = 8'h08;
    @(negedge clk) i_req = 8'h00;
    chk("t5_ovf", o_overflow, 1'b1);
    @(negedge clk);
    chk("t5_ovf_pulse", o_overflow, 1'b0);
    chk("t5_gnt_hold", o_gnt_onehot, 8'h08);
    i_gnt_ready = 1'b1;
    @(negedge clk);
    chk("t5_done", o_gnt_valid, 1'b0);
    chk("t5_pending", o_pending, 8'h00);
    chk_acc("t5_order", '{3});
    i_gnt_ready = 1'b0;

    // Accept index 6 with {1,7} pending: 7 wins over 1.
    acc_q.delete();
    @(negedge clk) i_req = 8'hC2;
    @(negedge clk) i_req = 8'h00;
    @(negedge clk);
    chk("t6_gnt6", o_gnt_onehot, 8'h40);
    i_gnt_ready = 1'b1;
    @(negedge clk);
    chk("t6_gnt7", o_gnt_onehot, 8'h80);
    chk("t6_pending", o_pending, 8'h82);
    @(negedge clk);
    chk("t6_gnt1", o_gnt_onehot, 8'h02);
    @(negedge clk);
    chk("t6_done", o_gnt_valid, 1'b0);
    chk_acc("t6_order", '{6, 7, 1});

    // Asynchronous reset in the middle of an offer.
    i_gnt_ready = 1'b0;
    @(negedge clk) i_req = 8'h01;
    @(negedge clk) i_req = 8'h00;
    @(negedge clk);
    chk("t7_offer", o_gnt_onehot, 8'h01);
    chk("t7_offer_valid", o_gnt_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_valid", o_gnt_valid, 1'b0);
    chk("t7_async_gnt", o_gnt_onehot, 8'h00);
    chk("t7_async_pending", o_pending, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t7_idle_after", o_gnt_valid, 1'b0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
